// File: rtl/freq_gen.sv
// Phase-accumulator square/pulse generator with programmable duty,
// burst length and period-boundary parameter updates.
module freq_gen #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             en_i,
    input  logic [ACC_W-1:0] step_i,
    input  logic [ACC_W-1:0] duty_i,
    input  logic [CNT_W-1:0] burst_i,
    input  logic             upd_i,
    output logic             upd_ack_o,
    output logic             gen_o,
    output logic             edge_o,
    output logic             done_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] per_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP,
        DONE
    } state_t;

    state_t           state_q, state_n;
    logic [ACC_W-1:0] acc_q, acc_n;
    logic [ACC_W-1:0] step_sh_q, step_sh_n;
    logic [ACC_W-1:0] duty_sh_q, duty_sh_n;
    logic [CNT_W-1:0] burst_sh_q, burst_sh_n;
    logic [ACC_W-1:0] step_st_q, step_st_n;
    logic [ACC_W-1:0] duty_st_q, duty_st_n;
    logic             pend_q, pend_n;
    logic             gen_n, edge_n, done_n, ack_n, busy_n;
    logic [CNT_W-1:0] per_cnt_n;

    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_sum;
    logic             wrap;
    logic [CNT_W-1:0] cnt_inc;
    logic             burst_hit;
    logic             apply;
    logic [ACC_W-1:0] duty_new;

    assign sum       = {1'b0, acc_q} + {1'b0, step_sh_q};
    assign acc_sum   = sum[ACC_W-1:0];
    assign wrap      = sum[ACC_W];
    assign cnt_inc   = per_cnt_o + CNT_W'(1);
    assign burst_hit = wrap && (burst_sh_q != '0) && (cnt_inc == burst_sh_q);
    assign apply     = wrap && pend_q;
    // A staged duty already governs the compare in the wrap cycle it lands in
    assign duty_new  = apply ? duty_st_q : duty_sh_q;

    always_comb begin
        state_n    = state_q;
        acc_n      = acc_q;
        step_sh_n  = step_sh_q;
        duty_sh_n  = duty_sh_q;
        burst_sh_n = burst_sh_q;
        step_st_n  = step_st_q;
        duty_st_n  = duty_st_q;
        pend_n     = pend_q;
        gen_n      = 1'b0;
        edge_n     = 1'b0;
        done_n     = 1'b0;
        ack_n      = 1'b0;
        per_cnt_n  = per_cnt_o;
        unique case (state_q)
            IDLE: begin
                acc_n = '0;
                if (en_i) begin
                    state_n    = RUN;
                    step_sh_n  = step_i;
                    duty_sh_n  = duty_i;
                    burst_sh_n = burst_i;
                    pend_n     = 1'b0;
                    edge_n     = 1'b1;
                    gen_n      = (duty_i != '0);
                    per_cnt_n  = '0;
                end
            end
            RUN, STOP: begin
                if (!en_i && (step_sh_q == '0)) begin
                    state_n = IDLE;
                    acc_n   = '0;
                end else if (burst_hit) begin
                    state_n   = en_i ? DONE : IDLE;
                    acc_n     = '0;
                    done_n    = 1'b1;
                    per_cnt_n = cnt_inc;
                end else if (wrap && !en_i) begin
                    state_n   = IDLE;
                    acc_n     = '0;
                    per_cnt_n = cnt_inc;
                end else begin
                    state_n = en_i ? RUN : STOP;
                    acc_n   = acc_sum;
                    gen_n   = (acc_sum < duty_new);
                    edge_n  = wrap;
                    if (wrap) begin
                        per_cnt_n = cnt_inc;
                    end
                    if (apply) begin
                        step_sh_n = step_st_q;
                        duty_sh_n = duty_st_q;
                        pend_n    = 1'b0;
                        ack_n     = 1'b1;
                    end
                end
                // Capture after any apply so a request on a wrap waits a period
                if (upd_i) begin
                    step_st_n = step_i;
                    duty_st_n = duty_i;
                    pend_n    = 1'b1;
                end
            end
            DONE: begin
                acc_n = '0;
                if (!en_i) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                acc_n   = '0;
            end
        endcase
        busy_n = (state_n == RUN) || (state_n == STOP);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            step_sh_q  <= '0;
            duty_sh_q  <= '0;
            burst_sh_q <= '0;
            step_st_q  <= '0;
            duty_st_q  <= '0;
            pend_q     <= 1'b0;
            gen_o      <= 1'b0;
            edge_o     <= 1'b0;
            done_o     <= 1'b0;
            upd_ack_o  <= 1'b0;
            busy_o     <= 1'b0;
            per_cnt_o  <= '0;
        end else begin
            state_q    <= state_n;
            acc_q      <= acc_n;
            step_sh_q  <= step_sh_n;
            duty_sh_q  <= duty_sh_n;
            burst_sh_q <= burst_sh_n;
            step_st_q  <= step_st_n;
            duty_st_q  <= duty_st_n;
            pend_q     <= pend_n;
            gen_o      <= gen_n;
            edge_o     <= edge_n;
            done_o     <= done_n;
            upd_ack_o  <= ack_n;
            busy_o     <= busy_n;
            per_cnt_o  <= per_cnt_n;
        end
    end

endmodule

// File: tb/tb_freq_gen.sv
// Directed self-checking bench for freq_gen.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_freq_gen;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        en_i;
    logic [31:0] step_i;
    logic [31:0] duty_i;
    logic [31:0] burst_i;
    logic        upd_i;
    logic        upd_ack_o;
    logic        gen_o;
    logic        edge_o;
    logic        done_o;
    logic        busy_o;
    logic [31:0] per_cnt_o;

    int errors = 0;
    int checks = 0;

    freq_gen #(.ACC_W(32), .CNT_W(32)) dut (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .en_i      (en_i),
        .step_i    (step_i),
        .duty_i    (duty_i),
        .burst_i   (burst_i),
        .upd_i     (upd_i),
        .upd_ack_o (upd_ack_o),
        .gen_o     (gen_o),
        .edge_o    (edge_o),
        .done_o    (done_o),
        .busy_o    (busy_o),
        .per_cnt_o (per_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // After this returns the first RUN cycle (i = 0) is being observed
    task automatic start(input logic [31:0] s, input logic [31:0] d,
                         input logic [31:0] b);
        step_i  = s;
        duty_i  = d;
        burst_i = b;
        en_i    = 1'b1;
        tick();
    endtask

    task automatic go_idle;
        en_i  = 1'b0;
        upd_i = 1'b0;
        repeat (20) tick();
    endtask

    task automatic test_reset;
        rstn_i  = 1'b0;
        en_i    = 1'b0;
        upd_i   = 1'b0;
        step_i  = '0;
        duty_i  = '0;
        burst_i = '0;
        #12;
        checks++;
        if ({gen_o, edge_o, done_o, upd_ack_o, busy_o} !== 5'b0 ||
            per_cnt_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_outs got=%b/%0d exp=00000/0",
                     {gen_o, edge_o, done_o, upd_ack_o, busy_o}, per_cnt_o);
        end
        @(negedge clk_i);
        rstn_i = 1'b1;
        tick();
        checks++;
        if (busy_o !== 1'b0 || gen_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b gen=%b exp=0/0",
                     busy_o, gen_o);
        end
    endtask

    task automatic test_continuous;
        logic eg, ee;
        start(32'h4000_0000, 32'h8000_0000, 32'd0);
        for (int i = 0; i < 13; i++) begin
            eg = ((i % 4) < 2);
            ee = ((i % 4) == 0);
            checks++;
            if (gen_o !== eg || edge_o !== ee || busy_o !== 1'b1) begin
                errors++;
                $display("FAIL cont_wave i=%0d got g=%b e=%b b=%b exp %b %b 1",
                         i, gen_o, edge_o, busy_o, eg, ee);
            end
            checks++;
            if (per_cnt_o !== 32'(i / 4)) begin
                errors++;
                $display("FAIL cont_cnt i=%0d got=%0d exp=%0d",
                         i, per_cnt_o, i / 4);
            end
            tick();
        end
        go_idle();
    endtask

    task automatic test_burst;
        int   highs;
        logic prev;
        highs = 0;
        prev  = 1'b0;
        start(32'h4000_0000, 32'h8000_0000, 32'd3);
        for (int i = 0; i < 12; i++) begin
            if (gen_o && !prev) highs++;
            prev = gen_o;
            checks++;
            if (done_o !== 1'b0 || gen_o !== ((i % 4) < 2)) begin
                errors++;
                $display("FAIL burst_run i=%0d got d=%b g=%b", i, done_o, gen_o);
            end
            tick();
        end
        checks++;
        if (done_o !== 1'b1 || gen_o !== 1'b0 || edge_o !== 1'b0 ||
            per_cnt_o !== 32'd3) begin
            errors++;
            $display("FAIL burst_done got d=%b g=%b e=%b n=%0d exp 1 0 0 3",
                     done_o, gen_o, edge_o, per_cnt_o);
        end
        checks++;
        if (highs !== 3) begin
            errors++;
            $display("FAIL burst_highs got=%0d exp=3", highs);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({done_o, gen_o, edge_o, busy_o} !== 4'b0 ||
                per_cnt_o !== 32'd3) begin
                errors++;
                $display("FAIL burst_hold i=%0d got=%b n=%0d exp=0000 3",
                         i, {done_o, gen_o, edge_o, busy_o}, per_cnt_o);
            end
        end
        go_idle();
        checks++;
        if (per_cnt_o !== 32'd3) begin
            errors++;
            $display("FAIL burst_keep got=%0d exp=3", per_cnt_o);
        end
    endtask

    task automatic test_update;
        logic eg, ee, ea;
        int   k;
        start(32'h4000_0000, 32'h8000_0000, 32'd0);
        tick();
        step_i = 32'h2000_0000;
        duty_i = 32'h8000_0000;
        upd_i  = 1'b1;
        tick();
        upd_i  = 1'b0;
        step_i = 32'h4000_0000;
        for (int i = 2; i < 21; i++) begin
            if (i < 4) begin
                eg = 1'b0;
                ee = 1'b0;
                ea = 1'b0;
            end else begin
                k  = i - 4;
                eg = ((k % 8) < 4);
                ee = ((k % 8) == 0);
                ea = (k == 0);
            end
            checks++;
            if (gen_o !== eg || edge_o !== ee || upd_ack_o !== ea) begin
                errors++;
                $display("FAIL upd_wave i=%0d got g=%b e=%b a=%b exp %b %b %b",
                         i, gen_o, edge_o, upd_ack_o, eg, ee, ea);
            end
            tick();
        end
        go_idle();
    endtask

    task automatic test_upd_at_wrap;
        logic ee, ea;
        start(32'h4000_0000, 32'h8000_0000, 32'd0);
        repeat (3) tick();
        step_i = 32'h2000_0000;
        upd_i  = 1'b1;
        tick();
        upd_i  = 1'b0;
        for (int i = 4; i < 17; i++) begin
            ee = (i == 4) || (i == 8) || (i == 16);
            ea = (i == 8);
            checks++;
            if (edge_o !== ee || upd_ack_o !== ea) begin
                errors++;
                $display("FAIL updwrap i=%0d got e=%b a=%b exp %b %b",
                         i, edge_o, upd_ack_o, ee, ea);
            end
            tick();
        end
        go_idle();
    endtask

    task automatic test_stop;
        logic eg, eb;
        start(32'h4000_0000, 32'hC000_0000, 32'd0);
        tick();
        en_i = 1'b0;
        for (int i = 1; i < 8; i++) begin
            eg = (i < 3);
            eb = (i < 4);
            checks++;
            if (gen_o !== eg || busy_o !== eb || edge_o !== 1'b0) begin
                errors++;
                $display("FAIL stop i=%0d got g=%b b=%b e=%b exp %b %b 0",
                         i, gen_o, busy_o, edge_o, eg, eb);
            end
            tick();
        end
        go_idle();
    endtask

    task automatic test_fractional;
        logic ee;
        start(32'h3000_0000, 32'h8000_0000, 32'd0);
        for (int i = 0; i < 17; i++) begin
            ee = (i == 0) || (i == 6) || (i == 11) || (i == 16);
            checks++;
            if (edge_o !== ee) begin
                errors++;
                $display("FAIL frac_edge i=%0d got=%b exp=%b", i, edge_o, ee);
            end
            if (i < 16) tick();
        end
        checks++;
        if (per_cnt_o !== 32'd3) begin
            errors++;
            $display("FAIL frac_cnt got=%0d exp=3", per_cnt_o);
        end
        go_idle();
    endtask

    task automatic test_boundaries;
        // duty 0: never high, edges still every 4
        start(32'h4000_0000, 32'h0, 32'd0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (gen_o !== 1'b0 || edge_o !== ((i % 4) == 0)) begin
                errors++;
                $display("FAIL duty0 i=%0d got g=%b e=%b", i, gen_o, edge_o);
            end
            tick();
        end
        go_idle();
        // duty above the largest acc value: always high
        start(32'h4000_0000, 32'hC000_0001, 32'd0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (gen_o !== 1'b1) begin
                errors++;
                $display("FAIL dutymax i=%0d got=%b exp=1", i, gen_o);
            end
            tick();
        end
        go_idle();
        // step 0: frozen, no wraps, burst never completes, stop is immediate
        start(32'h0, 32'h8000_0000, 32'd2);
        tick();
        for (int i = 1; i < 9; i++) begin
            checks++;
            if (gen_o !== 1'b1 || edge_o !== 1'b0 || done_o !== 1'b0 ||
                per_cnt_o !== 32'd0) begin
                errors++;
                $display("FAIL step0 i=%0d got g=%b e=%b d=%b n=%0d",
                         i, gen_o, edge_o, done_o, per_cnt_o);
            end
            tick();
        end
        en_i = 1'b0;
        tick();
        checks++;
        if (busy_o !== 1'b0 || gen_o !== 1'b0) begin
            errors++;
            $display("FAIL step0_stop got b=%b g=%b exp 0 0", busy_o, gen_o);
        end
        go_idle();
        // update request while idle is dropped
        step_i = 32'h2000_0000;
        upd_i  = 1'b1;
        tick();
        upd_i  = 1'b0;
        start(32'h4000_0000, 32'h8000_0000, 32'd0);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (upd_ack_o !== 1'b0 || edge_o !== ((i % 4) == 0)) begin
                errors++;
                $display("FAIL idle_upd i=%0d got a=%b e=%b", i, upd_ack_o, edge_o);
            end
            tick();
        end
        go_idle();
    endtask

    task automatic test_reset_midrun;
        start(32'h4000_0000, 32'h8000_0000, 32'd0);
        repeat (5) tick();
        #2;
        rstn_i = 1'b0;
        #1;
        checks++;
        if ({gen_o, edge_o, done_o, upd_ack_o, busy_o} !== 5'b0 ||
            per_cnt_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid got=%b/%0d exp=00000/0",
                     {gen_o, edge_o, done_o, upd_ack_o, busy_o}, per_cnt_o);
        end
        en_i = 1'b0;
        tick();
        rstn_i = 1'b1;
        repeat (3) tick();
        checks++;
        if (busy_o !== 1'b0 || gen_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_after got b=%b g=%b exp 0 0", busy_o, gen_o);
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_burst();
        test_update();
        test_upd_at_wrap();
        test_stop();
        test_fractional();
        test_boundaries();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
